// File: rtl/fc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fc_ctrl_pkg
// Description : Shared state encoding and helpers for the FC-layer sequencers.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_ctrl_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clear = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = c_st_idle,
        CLEAR = c_st_clear,
        RUN   = c_st_run,
        DRAIN = c_st_drain,
        DONE  = c_st_done
    } fc_seq_state_t;

    // Width of a counter indexing n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc2_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : fc2_sequencer_if
// Description : Scheduler handshake plus memory/PE control bundle of the FC2
//               sequencer. master = sequencer side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fc2_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 5
);
    logic              start;
    logic              stall;
    logic              busy;
    logic              acc_clr;
    logic              rd_en;
    logic [ADDR_W-1:0] addra;
    logic [IDX_W-1:0]  in_idx;
    logic              fc_valid;
    logic              done;

    modport master (
        input  start, stall,
        output busy, acc_clr, rd_en, addra, in_idx, fc_valid, done
    );

    modport slave (
        output start, stall,
        input  busy, acc_clr, rd_en, addra, in_idx, fc_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/fc2_sequencer_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : valid_delay
// Description : 1-bit strobe delay line, DEPTH cycles, async active-high reset.
//               Keeps strobes aligned with synchronous memory read data.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d_i,
    output logic      q_o
);

    logic [DEPTH-1:0] shift_q;

    if (DEPTH == 1) begin : g_single
        // Single-stage delay.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) shift_q <= '0;
            else       shift_q <= d_i;
        end
    end else begin : g_multi
        // Shift the strobe one stage per cycle, oldest stage at the top bit.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) shift_q <= '0;
            else       shift_q <= {shift_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = shift_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fc2_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc2_sequencer
// Description : Sequences one FC2 inference pass: clear accumulators, stream
//               INPUT_NODES weight/activation reads, strobe the PEs aligned
//               to read data, drain the PE pipeline and pulse done.
// Revision    : 1.0 - initial release
// ============================================================================
module fc2_sequencer
    import fc_ctrl_pkg::*;
#(
    parameter int INPUT_NODES = 20,
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int MEM_LAT     = 1,
    parameter int PE_LAT      = 2,
    parameter int IDX_W       = idx_width(INPUT_NODES)
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fc2_sequencer_if.master bus
);

    localparam int DRAIN_CYC = MEM_LAT + PE_LAT;
    localparam int DRAIN_W   = idx_width(DRAIN_CYC);

    localparam logic [IDX_W-1:0]   c_idx_last   = IDX_W'(INPUT_NODES - 1);
    localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'(DRAIN_CYC - 1);

    if (MEM_LAT < 1) begin : g_chk_lat
        $error("fc2_sequencer: MEM_LAT must be at least 1");
    end

    if ((longint'(BASE_ADDR) + longint'(INPUT_NODES) - 1) >= (64'sd1 <<< ADDR_W)) begin : g_chk_addr
        $error("fc2_sequencer: weight rows do not fit in ADDR_W address bits");
    end

    fc_seq_state_t      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               w_issue;
    logic               w_fc_valid;

    // A read is issued on every unstalled RUN cycle.
    assign w_issue = (state_q == RUN) && !bus.stall;

    // Next-state, index and drain-counter logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (w_issue) begin
                    // The index parks on the last input instead of wrapping.
                    if (idx_q == c_idx_last) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == c_drain_last) state_d = DONE;
                else                         drain_d = drain_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index and drain-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // fc_valid tracks rd_en through the memory read latency; it shifts in
    // every state so stall bubbles show up as gaps in the PE strobe.
    valid_delay #(
        .DEPTH (MEM_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .d_i   (w_issue),
        .q_o   (w_fc_valid)
    );

    assign bus.busy     = (state_q != IDLE);
    assign bus.acc_clr  = (state_q == CLEAR);
    assign bus.rd_en    = w_issue;
    assign bus.addra    = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
    assign bus.in_idx   = idx_q;
    assign bus.fc_valid = w_fc_valid;
    assign bus.done     = (state_q == DONE);

endmodule
`default_nettype wire
